fp16_mul_stream_adapter: RTL

- Valid/ready streaming front and back end for the 5-stage FP16 multiplier, which has no stall input.
- Accepts operand pairs and issues them into the multiplier. A valid bit travels through a delay line that matches the multiplier latency.
- Each result and its flags are captured into an output FIFO.
- A credit counter guarantees that every in-flight product has a FIFO slot, so back-pressure never loses data.

---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_sync_fifo_fwft.sv | 61 ++++++
 rtl/fp16_mul_stream_adapter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp16_pkg                                               |
// | Description : Shared constants, flag bit indices and the FIFO entry  |
// |               type for the FP16 arithmetic stream adapters.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fp16_pkg;

  localparam int FP16_DWIDTH      = 16;
  localparam int FP16_FLAG_W      = 5;
  localparam int FP16_MUL_LATENCY = 5;

  // Flag bit positions as produced by the arithmetic cores
  localparam int FLG_ANY  = 4;
  localparam int FLG_ANAN = 3;
  localparam int FLG_BNAN = 2;
  localparam int FLG_AINF = 1;
  localparam int FLG_BINF = 0;

  // One buffered product: the result word with its flags in the low bits
  typedef struct packed {
    logic [FP16_DWIDTH-1:0] result;
    logic [FP16_FLAG_W-1:0] flags;
  } fp16_mul_entry_t;

endpackage
`default_nettype wire

// File: rtl/fp16_sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp16_sync_fifo_fwft                                    |
// | Description : Single-clock first-word fall-through FIFO. The head    |
// |               entry is always visible on rdata while not empty.      |
// |               Pointers carry one extra wrap bit to tell full from    |
// |               empty.                                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fp16_sync_fifo_fwft #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wrEn;
  logic             w_rdEn;

  assign empty  = (r_wrPtr == r_rdPtr);
  assign full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign count  = r_wrPtr - r_rdPtr;
  assign rdata  = r_mem[r_rdPtr[AW-1:0]];
  assign w_rdEn = pop && !empty;
  // A write into a full FIFO is only safe when the head leaves in the same cycle
  assign w_wrEn = push && (!full || w_rdEn);

  // Pointer update; both pointers advance independently
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[r_wrPtr[AW-1:0]] <= wdata;
  end

  a_noOverflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_noUnderflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/fp16_mul_stream_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fp16_mul_stream_adapter                                |
// | Description : Valid/ready wrapper around the stall-free pipelined    |
// |               FP16 multiplier. A valid bit shadows each issued pair  |
// |               through the multiplier latency; results land in an     |
// |               output FIFO. A credit counter only admits a pair when  |
// |               a FIFO slot is guaranteed for its product.             |
// |               Optional macro FP16_FLAG_STICKY_EN adds a sticky OR of |
// |               all popped flags with a synchronous clear.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fp16_mul_stream_adapter
  import fp16_pkg::*;
#(
  parameter int DWIDTH      = FP16_DWIDTH,
  parameter int FLAG_W      = FP16_FLAG_W,
  parameter int MUL_LATENCY = FP16_MUL_LATENCY,
  parameter int DEPTH       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DWIDTH-1:0]      in_a,
  input  logic [DWIDTH-1:0]      in_b,
  output logic [DWIDTH-1:0]      mul_a,
  output logic [DWIDTH-1:0]      mul_b,
  input  logic [DWIDTH-1:0]      mul_result,
  input  logic [FLAG_W-1:0]      mul_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DWIDTH-1:0]      out_result,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [$clog2(DEPTH):0] occupancy,
  input  logic                   sticky_clr,
  output logic [FLAG_W-1:0]      sticky_flags
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam int            EW      = DWIDTH + FLAG_W;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [CW-1:0]          r_credit;
  logic [MUL_LATENCY-1:0] r_vpipe;
  logic                   w_fireIn;
  logic                   w_fireOut;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_fifoCount;
  logic [EW-1:0]          w_pushEntry;
  logic [EW-1:0]          w_headEntry;

  // Issue side: a zero operand pair is presented whenever nothing is issued
  assign in_ready  = (r_credit != '0);
  assign w_fireIn  = in_valid && in_ready;
  assign mul_a     = w_fireIn ? in_a : '0;
  assign mul_b     = w_fireIn ? in_b : '0;

  // Valid shadow of the multiplier pipeline
  generate
    if (MUL_LATENCY > 1) begin : g_vpipeShift
      always_ff @(posedge clk) begin
        if (rst) r_vpipe <= '0;
        else     r_vpipe <= {r_vpipe[MUL_LATENCY-2:0], w_fireIn};
      end
    end else begin : g_vpipeSingle
      always_ff @(posedge clk) begin
        if (rst) r_vpipe <= '0;
        else     r_vpipe <= w_fireIn;
      end
    end
  endgenerate

  assign w_push      = r_vpipe[MUL_LATENCY-1];
  assign w_pushEntry = {mul_result, mul_flags};

  // Credits: one is consumed per issued pair and returned per popped result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= C_DEPTH;
    end else begin
      case ({w_fireIn, w_fireOut})
        2'b10:   r_credit <= r_credit - 1'b1;
        2'b01:   r_credit <= r_credit + 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign occupancy = C_DEPTH - r_credit;

  fp16_sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata (w_pushEntry),
    .pop   (w_fireOut),
    .rdata (w_headEntry),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifoCount)
  );

  assign out_valid                = !w_empty;
  assign {out_result, out_flags}  = w_headEntry;
  assign w_fireOut                = out_valid && out_ready;

  // Every credit handed out is either still in the pipeline or sitting in the FIFO
  a_creditInvariant: assert property (@(posedge clk) disable iff (rst)
    ($countones(r_vpipe) + int'(w_fifoCount)) == int'(occupancy));
  a_fullMeansNoCredit: assert property (@(posedge clk) disable iff (rst)
    w_full |-> (r_credit == '0));

`ifdef FP16_FLAG_STICKY_EN
  logic [FLAG_W-1:0] r_sticky;

  // Sticky accumulation of popped flags; a clear overrides a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst || sticky_clr) r_sticky <= '0;
    else if (w_fireOut)    r_sticky <= r_sticky | out_flags;
  end

  assign sticky_flags = r_sticky;
`else
  logic w_unused_stickyClr;
  assign w_unused_stickyClr = sticky_clr;
  assign sticky_flags       = '0;
`endif

endmodule
`default_nettype wire
